// File: rtl/mult_div_if.sv
// Request/response bundle between the execute-stage control and the HI/LO multiply/divide unit.
// start is accepted only on a rising edge where busy=0; done pulses for one cycle once hi/lo hold the new result.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, dbg_state
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider holding the architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is applied in a single fix-up cycle.
module mult_div_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst_n,
    mult_div_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_bz;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_sgn;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_sgn   = bus.op[0];
        w_a_mag = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        w_b_mag = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // r_acc/r_q are shared: product high/low half for multiply, remainder/quotient for divide.
        w_madd  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shift = {r_acc, r_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_b};
        w_ge    = (w_shift >= {1'b0, r_b});

        if (r_div) begin
            w_acc_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_q_nx   = {r_q[WIDTH-2:0], w_ge};
        end else begin
            w_acc_nx = w_madd[WIDTH:1];
            w_q_nx   = {w_madd[0], r_q[WIDTH-1:1]};
        end

        w_prod = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
        w_quo  = r_bz ? {WIDTH{1'b1}} : (r_neg_q ? -r_q : r_q);
        w_rem  = r_neg_r ? -r_acc : r_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bz    <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (!bus.op[2]) begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_div   <= bus.op[1];
                            r_b     <= w_b_mag;
                            r_q     <= w_a_mag;
                            r_acc   <= '0;
                            r_neg_q <= w_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            r_neg_r <= w_sgn & bus.a[WIDTH-1];
                            r_bz    <= (bus.b == '0);
                        end else if (!bus.op[1]) begin
                            if (bus.op[0]) r_lo <= bus.a;
                            else           r_hi <= bus.a;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit at WIDTH=32 and WIDTH=8, checked against an arithmetic model.
module tb_mult_div_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(32)) if32();
  mult_div_if #(.WIDTH(8))  if8();

  mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [63:0] exp8_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic sig_done(int s);
    return (s != 0) ? if8.done : if32.done;
  endfunction

  function automatic logic sig_busy(int s);
    return (s != 0) ? if8.busy : if32.busy;
  endfunction

  function automatic logic [63:0] sig_hilo(int s);
    if (s != 0) return {24'd0, if8.hi, 24'd0, if8.lo};
    return {if32.hi, if32.lo};
  endfunction

  // ---------------- reference model ----------------
  task automatic model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ohi, input logic [31:0] olo,
                       output logic [31:0] nhi, output logic [31:0] nlo);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    nhi = ohi;
    nlo = olo;
    case (op)
      3'd0, 3'd1: begin
        if (op == 3'd0) p = ua * ub;
        else            p = 64'(sa * sb);
        nhi = 32'((p >> w) & mask);
        nlo = 32'(p & mask);
      end
      3'd2: begin
        if (ub == 0) begin nlo = 32'(mask); nhi = 32'(ua); end
        else begin nlo = 32'(ua / ub); nhi = 32'(ua % ub); end
      end
      3'd3: begin
        if (ub == 0) begin nlo = 32'(mask); nhi = 32'(ua); end
        else begin
          q = sa / sb;
          r = sa % sb;
          nlo = 32'(64'(q) & mask);
          nhi = 32'(64'(r) & mask);
        end
      end
      3'd4: nhi = 32'(ua);
      3'd5: nlo = 32'(ua);
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (s != 0) begin
      if8.start = st; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
    end else begin
      if32.start = st; if32.op = op; if32.a = a; if32.b = b;
    end
  endtask

  task automatic start_op(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    @(negedge clk);
    drive(s, 1'b1, op, a, b);
    if (op <= 3'd5) begin
      model((s != 0) ? 8 : 32, op, a, b, m_hi[s], m_lo[s], nh, nl);
      m_hi[s] = nh;
      m_lo[s] = nl;
      if (s != 0) exp8_q.push_back({nh, nl});
      else        exp_q.push_back({nh, nl});
    end
    @(posedge clk);
    #1;
    drive(s, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic wait_done(input int s, input int lat, input string name);
    int cyc = 0;
    int bcnt = 0;
    while (!sig_done(s) && cyc < 200) begin
      if (sig_busy(s)) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(lat));
    check({name, "_busy_cycles"}, 64'(bcnt + int'(sig_busy(s))), 64'(lat));
  endtask

  task automatic run_op(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op(s, op, a, b);
    wait_done(s, op[2] ? 0 : ((s != 0) ? 9 : 33), $sformatf("w%0d_op%0d", (s != 0) ? 8 : 32, op));
  endtask

  function automatic logic [31:0] pick(int w);
    logic [31:0] one = 32'd1;
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return one << (w - 1);
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  task automatic mon(input int s);
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (sig_done(s)) begin
        if (((s != 0) ? exp8_q.size() : exp_q.size()) == 0) begin
          check($sformatf("unexpected_done_dut%0d", s), 64'd1, 64'd0);
        end else begin
          e = (s != 0) ? exp8_q.pop_front() : exp_q.pop_front();
          check($sformatf("result_dut%0d", s), sig_hilo(s), e);
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;
    fork
      mon(0);
      mon(1);
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo32", sig_hilo(0), 64'd0);
    check("reset_flags32", {62'd0, sig_busy(0), sig_done(0)}, 64'd0);
    check("reset_hilo8", sig_hilo(1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 3'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg3x5", sig_hilo(0), 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", sig_hilo(0), 64'hFFFF_FFFE_0000_0001);
    run_op(0, 3'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", sig_hilo(0), 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(0, 3'd2, 32'd10, 32'd0);
    check("divu_by_zero", sig_hilo(0), 64'h0000_000A_FFFF_FFFF);
    run_op(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", sig_hilo(0), 64'h0000_0000_8000_0000);

    // a second request while busy must be dropped
    start_op(0, 3'd0, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 3'd2, 32'd100, 32'd3);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    wait_done(0, 28, "start_while_busy");
    check("multu_6x7", sig_hilo(0), 64'h0000_0000_0000_002A);
    run_op(0, 3'd4, 32'h1234_5678, 32'd0);
    check("mthi", sig_hilo(0), 64'h1234_5678_0000_002A);

    for (int i = 6; i < 8; i++) begin
      @(negedge clk);
      drive(0, 1'b1, 3'(i), $urandom, $urandom);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (2) begin
        check("reserved_flags", {62'd0, sig_busy(0), sig_done(0)}, 64'd0);
        check("reserved_hilo", sig_hilo(0), {m_hi[0], m_lo[0]});
        @(posedge clk);
        #1;
      end
    end

    // asynchronous reset in the middle of a divide
    start_op(0, 3'd2, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_hilo", sig_hilo(0), 64'd0);
    check("midop_reset_flags", {62'd0, sig_busy(0), sig_done(0)}, 64'd0);
    exp_q.delete();
    m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 3'd2, 32'd100, 32'd3);
    check("divu_after_reset", sig_hilo(0), 64'h0000_0001_0000_0021);

    run_op(1, 3'd1, 32'h80, 32'h80);
    check("w8_mult_80x80", sig_hilo(1), 64'h0000_0040_0000_0000);
    run_op(1, 3'd0, 32'hFF, 32'hFF);
    check("w8_back_to_back", sig_hilo(1), 64'h0000_00FE_0000_0001);

    for (int i = 0; i < 40; i++)
      run_op(0, 3'($urandom_range(0, 5)), pick(32), pick(32));
    for (int i = 0; i < 25; i++)
      run_op(1, 3'($urandom_range(0, 5)), pick(8), pick(8));

    repeat (3) @(posedge clk);
    check("queues_drained", 64'(exp_q.size() + exp8_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
